// File: rtl/simmem_mem_responder_pkg.sv
// Shared types and constants for the simmem memory-side responder.
package simmem_pkg;

  localparam int unsigned DataWidth     = 32;
  localparam int unsigned IdWidth       = 2;
  localparam int unsigned AddrWidth     = 32;
  localparam int unsigned BurstLenWidth = 8;

  localparam logic [1:0] RspOkay   = 2'b00;
  localparam logic [1:0] RspSlvErr = 2'b10;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_length;  // beats - 1
  } raddr_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_length;  // beats - 1
  } waddr_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } wdata_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           rsp;
    logic                 last;
  } rdata_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         rsp;
  } wresp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

endpackage

// File: rtl/simmem_mem_responder_if.sv
// Stream bundle between simmem (master) and the memory responder (slave).
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; a raised valid keeps its payload stable until that transfer.
interface simmem_mem_responder_if;
  import simmem_pkg::*;

  raddr_req_t raddr;
  logic       raddr_valid;
  logic       raddr_ready;
  waddr_req_t waddr;
  logic       waddr_valid;
  logic       waddr_ready;
  wdata_req_t wdata;
  logic       wdata_valid;
  logic       wdata_ready;
  rdata_t     rdata;
  logic       rdata_valid;
  logic       rdata_ready;
  wresp_t     wresp;
  logic       wresp_valid;
  logic       wresp_ready;

  modport master (
    output raddr, raddr_valid, waddr, waddr_valid, wdata, wdata_valid,
           rdata_ready, wresp_ready,
    input  raddr_ready, waddr_ready, wdata_ready, rdata, rdata_valid,
           wresp, wresp_valid
  );

  modport slave (
    input  raddr, raddr_valid, waddr, waddr_valid, wdata, wdata_valid,
           rdata_ready, wresp_ready,
    output raddr_ready, waddr_ready, wdata_ready, rdata, rdata_valid,
           wresp, wresp_valid
  );
endinterface

// File: rtl/simmem_mem_responder_mem_array.sv
// Word array: one synchronous write port, one combinational read port,
// cleared to zero by the asynchronous reset.
module simmem_mem_array #(
  parameter int unsigned Words = 64,
  parameter int unsigned Width = 32,
  localparam int unsigned IdxW = $clog2(Words)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IdxW-1:0]  waddr,
  input  logic [Width-1:0] wdata,
  input  logic [IdxW-1:0]  raddr,
  output logic [Width-1:0] rdata
);
  logic [Width-1:0] mem [Words];

  // Storage update; reads in the same cycle see the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Words; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/simmem_mem_responder.sv
// Memory-side responder: independent write and read FSMs over a word array.
module simmem_mem_responder
  import simmem_pkg::*;
#(
  parameter int unsigned MemWords = 64
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  simmem_mem_responder_if.slave bus,
  output w_state_e w_state_dbg,
  output r_state_e r_state_dbg
);
  localparam int unsigned IdxW = $clog2(MemWords);
  typedef logic [IdxW-1:0]          idx_t;
  typedef logic [BurstLenWidth-1:0] len_t;

  // Write-side registers
  w_state_e             w_state, w_state_d;
  logic [IdWidth-1:0]   w_id, w_id_d;
  idx_t                 w_idx, w_idx_d;
  len_t                 w_len, w_len_d, w_cnt, w_cnt_d;
  logic                 w_err, w_err_d;
  logic                 mem_we;
  wresp_t               wresp;

  // Read-side registers; the outgoing beat is held in r_beat
  r_state_e             r_state, r_state_d;
  logic [IdWidth-1:0]   r_id, r_id_d;
  idx_t                 r_idx, r_idx_d;
  len_t                 r_len, r_len_d, r_cnt, r_cnt_d;
  rdata_t               r_beat, r_beat_d;
  logic                 r_valid, r_valid_d;
  idx_t                 rd_idx;
  logic [DataWidth-1:0] rd_data;

  simmem_mem_array #(.Words(MemWords), .Width(DataWidth)) u_array (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .we    (mem_we),
    .waddr (w_idx),
    .wdata (bus.wdata.data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // Write FSM state and context registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_d;
      w_id    <= w_id_d;
      w_idx   <= w_idx_d;
      w_len   <= w_len_d;
      w_cnt   <= w_cnt_d;
      w_err   <= w_err_d;
    end
  end

  // Write FSM next state and outputs; a mis-placed or missing last marks SLVERR
  always_comb begin
    w_state_d       = w_state;
    w_id_d          = w_id;
    w_idx_d         = w_idx;
    w_len_d         = w_len;
    w_cnt_d         = w_cnt;
    w_err_d         = w_err;
    mem_we          = 1'b0;
    wresp           = '0;
    bus.waddr_ready = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.wresp_valid = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.waddr_ready = 1'b1;
        if (bus.waddr_valid) begin
          w_id_d    = bus.waddr.id;
          w_idx_d   = bus.waddr.addr[IdxW+1:2];
          w_len_d   = bus.waddr.burst_length;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        bus.wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx + idx_t'(1);
          w_cnt_d = w_cnt + len_t'(1);
          if (bus.wdata.last != (w_cnt == w_len)) w_err_d = 1'b1;
          if (w_cnt == w_len) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bus.wresp_valid = 1'b1;
        wresp.id        = w_id;
        wresp.rsp       = w_err ? RspSlvErr : RspOkay;
        if (bus.wresp_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign bus.wresp = wresp;

  // Read FSM state, context and registered beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= r_state_d;
      r_id    <= r_id_d;
      r_idx   <= r_idx_d;
      r_len   <= r_len_d;
      r_cnt   <= r_cnt_d;
      r_beat  <= r_beat_d;
      r_valid <= r_valid_d;
    end
  end

  // Read FSM: the array is read for the beat that will be presented next cycle
  always_comb begin
    r_state_d       = r_state;
    r_id_d          = r_id;
    r_idx_d         = r_idx;
    r_len_d         = r_len;
    r_cnt_d         = r_cnt;
    r_beat_d        = r_beat;
    r_valid_d       = r_valid;
    rd_idx          = '0;
    bus.raddr_ready = 1'b0;
    case (r_state)
      R_IDLE: begin
        bus.raddr_ready = 1'b1;
        rd_idx          = bus.raddr.addr[IdxW+1:2];
        if (bus.raddr_valid) begin
          r_id_d        = bus.raddr.id;
          r_idx_d       = rd_idx;
          r_len_d       = bus.raddr.burst_length;
          r_cnt_d       = '0;
          r_beat_d.id   = bus.raddr.id;
          r_beat_d.data = rd_data;
          r_beat_d.rsp  = RspOkay;
          r_beat_d.last = (bus.raddr.burst_length == '0);
          r_valid_d     = 1'b1;
          r_state_d     = R_BURST;
        end
      end
      R_BURST: begin
        rd_idx = r_idx + idx_t'(1);
        if (bus.rdata_ready) begin
          if (r_cnt == r_len) begin
            r_valid_d = 1'b0;
            r_beat_d  = '0;
            r_state_d = R_IDLE;
          end else begin
            r_idx_d       = rd_idx;
            r_cnt_d       = r_cnt + len_t'(1);
            r_beat_d.id   = r_id;
            r_beat_d.data = rd_data;
            r_beat_d.rsp  = RspOkay;
            r_beat_d.last = (r_cnt_d == r_len);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign bus.rdata       = r_beat;
  assign bus.rdata_valid = r_valid;
  assign w_state_dbg     = w_state;
  assign r_state_dbg     = r_state;
endmodule

// File: tb/tb_simmem_mem_responder.sv
// Directed bench for simmem_mem_responder with a queue-based scoreboard.
module tb_simmem_mem_responder;
  import simmem_pkg::*;

  localparam int RW = $bits(rdata_t);
  localparam int WW = $bits(wresp_t);

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  simmem_mem_responder_if bus();
  w_state_e w_state_dbg;
  r_state_e r_state_dbg;

  simmem_mem_responder #(.MemWords(64)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .w_state_dbg (w_state_dbg),
    .r_state_dbg (r_state_dbg)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_r_q[$];
  logic [WW-1:0] exp_w_q[$];
  int rd_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every transfer against the queue, checks stall stability
  logic   r_stall, w_stall;
  rdata_t r_held;
  wresp_t w_held;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_stall = 1'b0;
      w_stall = 1'b0;
    end else begin
      if (r_stall) begin
        check("rdata_hold_valid", 64'(bus.rdata_valid), 64'd1);
        check("rdata_hold_payload", 64'(bus.rdata), 64'(r_held));
      end
      if (w_stall) begin
        check("wresp_hold_valid", 64'(bus.wresp_valid), 64'd1);
        check("wresp_hold_payload", 64'(bus.wresp), 64'(w_held));
      end
      if (bus.rdata_valid && bus.rdata_ready) begin
        if (exp_r_q.size() == 0) fail_now("rdata_unexpected");
        else check("rdata", 64'(bus.rdata), 64'(exp_r_q.pop_front()));
        rd_cyc_q.push_back(cyc);
      end
      if (bus.wresp_valid && bus.wresp_ready) begin
        if (exp_w_q.size() == 0) fail_now("wresp_unexpected");
        else check("wresp", 64'(bus.wresp), 64'(exp_w_q.pop_front()));
      end
      r_stall = bus.rdata_valid && !bus.rdata_ready;
      r_held  = bus.rdata;
      w_stall = bus.wresp_valid && !bus.wresp_ready;
      w_held  = bus.wresp;
    end
  end

  // Driver tasks; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_r(input logic [1:0] id, input logic [31:0] data, input logic last);
    rdata_t r;
    r.id = id; r.data = data; r.rsp = RspOkay; r.last = last;
    exp_r_q.push_back(r);
  endtask

  task automatic push_w(input logic [1:0] id, input logic [1:0] rsp);
    wresp_t w;
    w.id = id; w.rsp = rsp;
    exp_w_q.push_back(w);
  endtask

  task automatic send_waddr(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.waddr = '{id: id, addr: addr, burst_length: len};
    bus.waddr_valid = 1'b1;
    while (!bus.waddr_ready && n < 50) begin tick(); n++; end
    if (n == 50) fail_now("waddr_timeout");
    tick();
    bus.waddr_valid = 1'b0;
  endtask

  task automatic send_wbeat(input logic [31:0] data, input logic last);
    int n = 0;
    bus.wdata = '{data: data, last: last};
    bus.wdata_valid = 1'b1;
    while (!bus.wdata_ready && n < 50) begin tick(); n++; end
    if (n == 50) fail_now("wdata_timeout");
    tick();
    bus.wdata_valid = 1'b0;
  endtask

  task automatic send_raddr(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.raddr = '{id: id, addr: addr, burst_length: len};
    bus.raddr_valid = 1'b1;
    while (!bus.raddr_ready && n < 50) begin tick(); n++; end
    if (n == 50) fail_now("raddr_timeout");
    tick();
    bus.raddr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_r_q.size() != 0 || exp_w_q.size() != 0) && n < 200) begin tick(); n++; end
    if (n == 200) fail_now("drain_timeout");
  endtask

  // Directed sequence
  initial begin
    rst_n = 1'b0;
    bus.raddr = '0; bus.raddr_valid = 1'b0;
    bus.waddr = '0; bus.waddr_valid = 1'b0;
    bus.wdata = '0; bus.wdata_valid = 1'b0;
    bus.rdata_ready = 1'b1;
    bus.wresp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata_valid", 64'(bus.rdata_valid), 64'd0);
    check("rst_wresp_valid", 64'(bus.wresp_valid), 64'd0);
    check("rst_raddr_ready", 64'(bus.raddr_ready), 64'd1);
    check("rst_waddr_ready", 64'(bus.waddr_ready), 64'd1);
    check("rst_wdata_ready", 64'(bus.wdata_ready), 64'd0);
    check("rst_rdata_payload", 64'(bus.rdata), 64'd0);
    check("rst_wresp_payload", 64'(bus.wresp), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single write to word 4
    push_w(2'd1, RspOkay);
    send_waddr(2'd1, 32'h10, 8'd0);
    send_wbeat(32'hA5A5_A5A5, 1'b1);
    check("wresp_one_cycle_after_beat", 64'(bus.wresp_valid), 64'd1);
    drain();
    check("waddr_ready_after_resp", 64'(bus.waddr_ready), 64'd1);

    // Readback burst over words 3..5, ready held high
    rd_cyc_q.delete();
    push_r(2'd2, 32'h0, 1'b0);
    push_r(2'd2, 32'hA5A5_A5A5, 1'b0);
    push_r(2'd2, 32'h0, 1'b1);
    send_raddr(2'd2, 32'h0C, 8'd2);
    check("rdata_valid_after_accept", 64'(bus.rdata_valid), 64'd1);
    drain();
    check("burst_beat_count", 64'(rd_cyc_q.size()), 64'd3);
    if (rd_cyc_q.size() == 3) check("burst_no_bubbles", 64'(rd_cyc_q[2] - rd_cyc_q[0]), 64'd2);
    check("rdata_valid_after_last", 64'(bus.rdata_valid), 64'd0);
    check("raddr_ready_after_last", 64'(bus.raddr_ready), 64'd1);

    // Wrap from word 63 to word 0
    push_w(2'd3, RspOkay);
    send_waddr(2'd3, 32'hFC, 8'd1);
    send_wbeat(32'h1111_1111, 1'b0);
    send_wbeat(32'h2222_2222, 1'b1);
    drain();
    push_r(2'd0, 32'h1111_1111, 1'b0);
    push_r(2'd0, 32'h2222_2222, 1'b1);
    send_raddr(2'd0, 32'hFC, 8'd1);
    drain();
    push_r(2'd1, 32'h2222_2222, 1'b1);
    send_raddr(2'd1, 32'h0, 8'd0);
    drain();

    // Early last -> SLVERR, both beats still land in words 8 and 9
    push_w(2'd2, RspSlvErr);
    send_waddr(2'd2, 32'h20, 8'd1);
    send_wbeat(32'h3333_3333, 1'b1);
    send_wbeat(32'h4444_4444, 1'b0);
    drain();
    push_r(2'd2, 32'h3333_3333, 1'b0);
    push_r(2'd2, 32'h4444_4444, 1'b1);
    send_raddr(2'd2, 32'h20, 8'd1);
    drain();

    // Missing last on a single-beat write -> SLVERR
    push_w(2'd0, RspSlvErr);
    send_waddr(2'd0, 32'h40, 8'd0);
    send_wbeat(32'h5555_5555, 1'b0);
    drain();

    // Backpressure on a 4-beat read of words 7..10
    push_r(2'd3, 32'h0, 1'b0);
    push_r(2'd3, 32'h3333_3333, 1'b0);
    push_r(2'd3, 32'h4444_4444, 1'b0);
    push_r(2'd3, 32'h0, 1'b1);
    bus.rdata_ready = 1'b0;
    send_raddr(2'd3, 32'h1C, 8'd3);
    for (int i = 0; i < 30 && exp_r_q.size() != 0; i++) begin
      bus.rdata_ready = ~bus.rdata_ready;
      tick();
    end
    bus.rdata_ready = 1'b1;
    drain();

    // Same-cycle write and read of word 4: the read sees the old value
    push_w(2'd0, RspOkay);
    push_r(2'd1, 32'hA5A5_A5A5, 1'b1);
    send_waddr(2'd0, 32'h10, 8'd0);
    fork
      send_raddr(2'd1, 32'h10, 8'd0);
      send_wbeat(32'h6666_6666, 1'b1);
    join
    drain();
    push_r(2'd2, 32'h6666_6666, 1'b1);
    send_raddr(2'd2, 32'h10, 8'd0);
    drain();

    // Reset in the middle of a stalled read burst
    bus.rdata_ready = 1'b0;
    send_raddr(2'd1, 32'h1C, 8'd3);
    tick();
    check("pre_reset_rdata_valid", 64'(bus.rdata_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdata_valid", 64'(bus.rdata_valid), 64'd0);
    check("mid_rst_wresp_valid", 64'(bus.wresp_valid), 64'd0);
    check("mid_rst_raddr_ready", 64'(bus.raddr_ready), 64'd1);
    check("mid_rst_waddr_ready", 64'(bus.waddr_ready), 64'd1);
    check("mid_rst_wdata_ready", 64'(bus.wdata_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.rdata_ready = 1'b1;
    tick();
    push_r(2'd0, 32'h0, 1'b1);
    send_raddr(2'd0, 32'h10, 8'd0);
    drain();
    push_r(2'd3, 32'h0, 1'b1);
    send_raddr(2'd3, 32'hFC, 8'd0);
    drain();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
